// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core: opcodes, functs,
// FSM states, ALU operations, immediate formats and immediate generation.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I, IMM_S, IMM_B, IMM_J
  } imm_fmt_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL
  } instr_cls_e;

  // Sign-extended immediate for the given instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU shared by the single-cycle and multi-cycle cores.
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        eq
);

  // Select the operation result; SLT compares as signed.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32I-subset core: one instruction in flight, sequenced through
// FETCH/DECODE/EXEC/MEM/WB, halting permanently on illegal or misaligned events.
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_aluout, r_target, r_mdr;
  alu_op_e     r_aluop;
  instr_cls_e  r_cls;
  logic        r_use_imm, r_dmem_req, r_retire, r_halted;
  logic [31:0] r_regs [NUM_REGS];

  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic        w_legal, w_use_imm;
  instr_cls_e  w_cls;
  alu_op_e     w_aluop;
  imm_fmt_e    w_fmt;
  logic [31:0] w_alu_b, w_alu_result, w_pc_plus4, w_pc_imm, w_next_pc, w_rf_wdata;
  logic        w_alu_eq, w_taken, w_exec_fault, w_rf_we;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  // Register file reads: x0 and unimplemented indices read as zero.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    if (w_rs1 != '0 && {27'b0, w_rs1} < NUM_REGS) w_rs1_val = r_regs[w_rs1[IDX_W-1:0]];
    if (w_rs2 != '0 && {27'b0, w_rs2} < NUM_REGS) w_rs2_val = r_regs[w_rs2[IDX_W-1:0]];
  end

  // Instruction decode into class, ALU op, immediate format and legality.
  always_comb begin
    w_legal   = 1'b0;
    w_cls     = CLS_ALU;
    w_aluop   = ALU_ADD;
    w_fmt     = IMM_I;
    w_use_imm = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_legal = 1'b1;
        if (w_funct7 == F7_SUB && w_funct3 == F3_ADD_SUB) begin
          w_aluop = ALU_SUB;
        end else if (w_funct7 != F7_BASE) begin
          w_legal = 1'b0;
        end else begin
          case (w_funct3)
            F3_ADD_SUB: w_aluop = ALU_ADD;
            F3_SLT:     w_aluop = ALU_SLT;
            F3_XOR:     w_aluop = ALU_XOR;
            F3_OR:      w_aluop = ALU_OR;
            F3_AND:     w_aluop = ALU_AND;
            default:    w_legal = 1'b0;
          endcase
        end
      end
      OPC_OPIMM: begin
        w_legal   = (w_funct3 == F3_ADD_SUB);
        w_use_imm = 1'b1;
      end
      OPC_LOAD: begin
        w_legal   = (w_funct3 == F3_LW);
        w_cls     = CLS_LOAD;
        w_use_imm = 1'b1;
      end
      OPC_STORE: begin
        w_legal   = (w_funct3 == F3_SW);
        w_cls     = CLS_STORE;
        w_fmt     = IMM_S;
        w_use_imm = 1'b1;
      end
      OPC_BRANCH: begin
        w_legal = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE);
        w_cls   = CLS_BRANCH;
        w_fmt   = IMM_B;
        w_aluop = ALU_SUB;
      end
      OPC_JAL: begin
        w_legal = 1'b1;
        w_cls   = CLS_JAL;
        w_fmt   = IMM_J;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_alu_b = r_use_imm ? r_imm : r_b;

  riscv_alu u_alu (
    .op     (r_aluop),
    .a      (r_a),
    .b      (w_alu_b),
    .result (w_alu_result),
    .eq     (w_alu_eq)
  );

  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_pc_imm     = r_pc + r_imm;
  assign w_taken      = (r_cls == CLS_BRANCH) && ((w_funct3 == F3_BEQ) ? w_alu_eq : !w_alu_eq);
  assign w_next_pc    = (w_taken || r_cls == CLS_JAL) ? w_pc_imm : w_pc_plus4;
  assign w_exec_fault = (r_cls == CLS_LOAD || r_cls == CLS_STORE) ? (w_alu_result[1:0] != 2'b00)
                                                                  : (w_next_pc[1:0] != 2'b00);

  assign w_rf_we    = (r_state == S_WB) && (r_cls == CLS_ALU || r_cls == CLS_LOAD || r_cls == CLS_JAL)
                      && (w_rd != '0) && ({27'b0, w_rd} < NUM_REGS);
  assign w_rf_wdata = (r_cls == CLS_LOAD) ? r_mdr : r_aluout;

  // Main sequencer: one instruction at a time, registered retire/halt/dmem request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_aluout   <= '0;
      r_target   <= '0;
      r_mdr      <= '0;
      r_aluop    <= ALU_ADD;
      r_cls      <= CLS_ALU;
      r_use_imm  <= 1'b0;
      r_dmem_req <= 1'b0;
      r_retire   <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_a       <= w_rs1_val;
            r_b       <= w_rs2_val;
            r_imm     <= imm_gen(r_ir, w_fmt);
            r_aluop   <= w_aluop;
            r_cls     <= w_cls;
            r_use_imm <= w_use_imm;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_aluout <= (r_cls == CLS_JAL) ? w_pc_plus4 : w_alu_result;
          r_target <= w_next_pc;
          if (w_exec_fault) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (r_cls == CLS_LOAD || r_cls == CLS_STORE) begin
            r_dmem_req <= 1'b1;
            r_state    <= S_MEM;
          end else begin
            r_retire <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (r_cls == CLS_LOAD) r_mdr <= dmem_rdata;
            r_dmem_req <= 1'b0;
            r_retire   <= 1'b1;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= r_target;
          r_state <= S_FETCH;
        end
        S_HALT: ;
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase
    end
  end

  // Architectural register writeback during WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_rf_we) begin
      r_regs[w_rd[IDX_W-1:0]] <= w_rf_wdata;
    end
  end

  // Fetch request is gated by rst so it drops the moment reset rises.
  assign imem_req   = (r_state == S_FETCH) && !rst;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = (r_cls == CLS_STORE);
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_b;
  assign pc         = r_pc;
  assign retire     = r_retire;
  assign halted     = r_halted;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Scoreboard bench for riscv_multicycle: directed program, expected retire and
// data-bus transactions queued up front, checked by a negedge monitor.
module tb_riscv_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc;
  logic        retire, halted;

  riscv_multicycle #(.NUM_REGS(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; int cycle; } ret_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int reqc; } dtx_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   iw, dw, dcnt;
  ret_t exp_ret[$];
  dtx_t exp_d[$];
  ret_t er;
  dtx_t ed;

  logic [31:0] imem [32];
  logic [31:0] dmem [logic [31:0]];

  localparam int N = 19;
  logic [31:0] t_pc  [N];
  logic [31:0] t_ins [N];
  int          t_len [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle count since reset release (cycle number = cyc + 1 when sampled at negedge).
  initial forever begin
    @(posedge clk);
    if (rst) cyc = 0; else cyc++;
  end

  // Instruction memory: zero-wait except two wait cycles for the fetch at 0x38.
  initial begin
    imem_ack = 1'b0; imem_rdata = '0; iw = 0;
    forever begin
      @(posedge clk); #2;
      if (imem_req) begin
        if (iw >= ((imem_addr == 32'h38) ? 2 : 0)) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr[6:2]];
        end else begin
          imem_ack = 1'b0; iw++;
        end
      end else begin
        imem_ack = 1'b0; iw = 0;
      end
    end
  end

  // Data memory: three wait cycles on every access.
  initial begin
    dmem_ack = 1'b0; dmem_rdata = '0; dw = 0;
    forever begin
      @(posedge clk); #2;
      if (dmem_req) begin
        if (dw >= 3) begin
          dmem_ack = 1'b1;
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          else dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 32'h0;
        end else begin
          dmem_ack = 1'b0; dw++;
        end
      end else begin
        dmem_ack = 1'b0; dw = 0;
      end
    end
  end

  // Monitor: pop and compare on each retire pulse and each completed data access.
  initial begin
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dcnt = 0;
      end else begin
        if (retire) begin
          if (exp_ret.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_retire: got retire at pc 0x%08h expected none", pc);
          end else begin
            er = exp_ret.pop_front();
            check("retire_pc", pc, er.pc);
            check("retire_cycle", 32'(cyc + 1), 32'(er.cycle));
          end
        end
        if (dmem_req) begin
          dcnt++;
          if (dmem_ack) begin
            if (exp_d.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_dmem: got access at 0x%08h expected none", dmem_addr);
            end else begin
              ed = exp_d.pop_front();
              check("dmem_we", 32'(dmem_we), 32'(ed.we));
              check("dmem_addr", dmem_addr, ed.addr);
              if (ed.we) check("dmem_wdata", dmem_wdata, ed.wdata);
              check("dmem_req_cycles", 32'(dcnt), 32'(ed.reqc));
            end
            dcnt = 0;
          end
        end else begin
          dcnt = 0;
        end
      end
    end
  end

  // Stimulus: program load, run to halt, then reset during a data request.
  initial begin
    int total, hcyc, seen;
    t_pc  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h30, 32'h34,
              32'h38, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58};
    t_ins = '{32'h00A00093, 32'h00300113, 32'h402081B3, 32'h04302023, 32'h00108463,
              32'h00109463, 32'h04002203, 32'h010000EF, 32'h04402223, 32'h04102423,
              32'h00500013, 32'h00500493, 32'h009002B3, 32'h04502623, 32'hFFF00113,
              32'h00312333, 32'h0040E3B3, 32'h04602823, 32'h04702A23};
    t_len = '{4, 4, 4, 8, 4, 4, 8, 4, 8, 8, 6, 4, 4, 8, 4, 4, 4, 8, 8};
    for (int i = 0; i < 32; i++) imem[i] = 32'hFFFF_FFFF;
    total = 0;
    for (int i = 0; i < N; i++) begin
      imem[t_pc[i][6:2]] = t_ins[i];
      total += t_len[i];
      exp_ret.push_back('{pc: t_pc[i], cycle: total});
    end
    exp_d.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'd7,    reqc: 4});
    exp_d.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'd0,    reqc: 4});
    exp_d.push_back('{we: 1'b1, addr: 32'h44, wdata: 32'd7,    reqc: 4});
    exp_d.push_back('{we: 1'b1, addr: 32'h48, wdata: 32'h24,   reqc: 4});
    exp_d.push_back('{we: 1'b1, addr: 32'h4C, wdata: 32'd0,    reqc: 4});
    exp_d.push_back('{we: 1'b1, addr: 32'h50, wdata: 32'd1,    reqc: 4});
    exp_d.push_back('{we: 1'b1, addr: 32'h54, wdata: 32'h27,   reqc: 4});

    repeat (3) @(posedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    rst = 1'b0;

    hcyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (halted) begin hcyc = cyc + 1; break; end
    end
    check("halt_cycle", 32'(hcyc), 32'd109);
    check("halt_pc", pc, 32'h5C);
    check("halt_imem_req", 32'(imem_req), 32'd0);
    repeat (5) @(negedge clk);
    check("halt_pc_frozen", pc, 32'h5C);
    check("halt_imem_req_held", 32'(imem_req), 32'd0);
    check("halt_dmem_req", 32'(dmem_req), 32'd0);
    check("halt_sticky", 32'(halted), 32'd1);
    check("retires_outstanding", 32'(exp_ret.size()), 32'd0);
    check("dmem_outstanding", 32'(exp_d.size()), 32'd0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_ret.push_back('{pc: t_pc[i], cycle: 4 * (i + 1)});
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dmem_req) begin seen = 1; break; end
    end
    check("dmem_req_seen", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_dmem_req_drop", 32'(dmem_req), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("run2_retires", 32'(exp_ret.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_ret.push_back('{pc: 32'h0, cycle: 4});
    @(negedge clk);
    check("post_rst_fetch_req", 32'(imem_req), 32'd1);
    check("post_rst_fetch_addr", imem_addr, 32'h0);
    repeat (5) @(negedge clk);
    check("post_rst_retires", 32'(exp_ret.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
